// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, widths and helpers for the
// UART transmit scheduler.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_GAP
    } sched_state_t;

    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward
// from the requester after last_grant and wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [CLOG2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]        grant,
    output logic [CLOG2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDW = CLOG2(NUM_REQ);

    logic [NUM_REQ-1:0] cand;
    logic               found;
    int                 idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx  = (int'(last_grant) + i) % NUM_REQ;
            cand = NUM_REQ'(1) << idx;
            if (!found && |(req & cand)) begin
                found     = 1'b1;
                grant     = cand;
                grant_idx = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter among NUM_REQ
// byte producers, launching each frame exactly once.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [UART_DATA_W-1:0]          tx_data,
    output logic                            tx_start,
    input  logic                            tx_busy,
    output logic [CLOG2(NUM_REQ)-1:0]       grant_id,
    output logic                            active,
    output logic                            err_timeout
);

    localparam int IDW  = CLOG2(NUM_REQ);
    localparam int CNTW = CLOG2(START_TIMEOUT + 1);

    sched_state_t           state;
    sched_state_t           state_nx;
    logic [UART_DATA_W-1:0] hold_reg;
    logic [UART_DATA_W-1:0] win_data;
    logic [IDW-1:0]         last_grant;
    logic [IDW-1:0]         arb_idx;
    logic [NUM_REQ-1:0]     arb_grant;
    logic [CNTW-1:0]        cnt;
    logic                   accept;
    logic                   timeout_hit;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .last_grant(last_grant),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign win_data =
        UART_DATA_W'(req_data >> (UART_DATA_W * int'(arb_idx)));

    assign tx_data = hold_reg;

    always_comb begin
        state_nx    = state;
        req_ready   = '0;
        tx_start    = 1'b0;
        active      = 1'b1;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            S_IDLE: begin
                active = 1'b0;
                if (|req_valid) begin
                    req_ready = arb_grant;
                    accept    = 1'b1;
                    state_nx  = S_LOAD;
                end
            end
            S_LOAD: state_nx = S_START;
            S_START: begin
                tx_start = 1'b1;
                if (tx_busy) begin
                    state_nx = S_WAIT;
                end else if (cnt == CNTW'(START_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nx    = S_GAP;
                end
            end
            S_WAIT: begin
                if (!tx_busy) state_nx = S_GAP;
            end
            S_GAP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Counter is cleared while in LOAD so it starts at 0 on START entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            hold_reg    <= '0;
            grant_id    <= '0;
            last_grant  <= IDW'(NUM_REQ - 1);
            cnt         <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            err_timeout <= timeout_hit;
            if (accept) begin
                hold_reg   <= win_data;
                grant_id   <= arb_idx;
                last_grant <= arb_idx;
            end
            if (state == S_LOAD) begin
                cnt <= '0;
            end else if (state == S_START) begin
                cnt <= cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and randomized checks of the
// scheduler against a round-robin reference model.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        err_timeout;

    logic [7:0]  dat [4];
    int          checks;
    int          passes;
    int          last_g;
    int          id;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    uart_tx_scheduler #(
        .NUM_REQ      (4),
        .START_TIMEOUT(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .active     (active),
        .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: first valid requester after the previous winner.
    function automatic int rr_pick(input logic [3:0] v, input int last);
        for (int i = 1; i <= 4; i++) begin
            int c = (last + i) % 4;
            if (((v >> c) & 4'd1) != 4'd0) return c;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 0);
        check({tag, "_start"}, 32'(tx_start), 0);
        check({tag, "_data"}, 32'(tx_data), 0);
        check({tag, "_gid"}, 32'(grant_id), 0);
        check({tag, "_active"}, 32'(active), 0);
        check({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    // Waits for the grant, follows LOAD and stops at the first START cycle.
    task automatic accept_phase(input int keep, output int wid);
        int n;
        logic [7:0] b;
        #1;
        n = 0;
        wid = rr_pick(req_valid, last_g);
        while (req_ready == 4'd0 && n < 20) begin
            tick();
            n++;
        end
        check("ready_onehot", 32'(req_ready), 32'(1) << wid);
        check("idle_active", 32'(active), 0);
        b = dat[wid];
        last_g = wid;
        tick();
        if (keep != 0) dat[wid] = 8'($urandom);
        else req_valid &= ~(4'(1) << wid);
        check("load_data", 32'(tx_data), 32'(b));
        check("load_start", 32'(tx_start), 0);
        check("grant_id", 32'(grant_id), wid);
        check("load_ready", 32'(req_ready), 0);
        tick();
        check("start_high", 32'(tx_start), 1);
        check("start_data", 32'(tx_data), 32'(b));
    endtask

    // Transmitter model: busy rises dly cycles after start, lasts len.
    task automatic busy_phase(input int dly, input int len,
                              input logic [3:0] pulse);
        for (int k = 1; k < dly; k++) begin
            tick();
            check("start_hold", 32'(tx_start), 1);
        end
        tick();
        tx_busy = 1'b1;
        tick();
        check("wait_start_low", 32'(tx_start), 0);
        check("wait_active", 32'(active), 1);
        check("wait_err", 32'(err_timeout), 0);
        for (int k = 0; k < len; k++) begin
            if (k == 0) req_valid |= pulse;
            if (k == 1) req_valid &= ~pulse;
            #1;
            check("wait_ready", 32'(req_ready), 0);
            check("wait_start", 32'(tx_start), 0);
            tick();
        end
        tx_busy = 1'b0;
        tick();
        check("gap_active", 32'(active), 1);
        check("gap_start", 32'(tx_start), 0);
        tick();
        check("idle_after_busy", 32'(active), 0);
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        last_g    = 3;
        rst_n     = 1'b0;
        req_valid = 4'd0;
        tx_busy   = 1'b0;
        for (int i = 0; i < 4; i++) dat[i] = 8'd0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single request
        dat[0]    = 8'h5A;
        req_valid = 4'b0001;
        accept_phase(0, id);
        busy_phase(2, 100, 4'd0);

        // Simultaneous requests 1 and 3
        dat[1]    = 8'($urandom);
        dat[3]    = 8'($urandom);
        req_valid = 4'b1010;
        accept_phase(0, id);
        busy_phase(2, 20, 4'd0);
        accept_phase(0, id);
        busy_phase(3, 20, 4'd0);

        // Fairness: everyone valid for 8 frames
        for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
        req_valid = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            accept_phase(1, id);
            busy_phase(int'($urandom_range(3, 2)),
                       int'($urandom_range(12, 3)), 4'd0);
        end
        req_valid = 4'd0;

        // Random masks and data
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) dat[i] = 8'($urandom);
            req_valid = 4'($urandom_range(15, 1));
            accept_phase(0, id);
            busy_phase(int'($urandom_range(3, 2)),
                       int'($urandom_range(30, 2)), 4'd0);
            req_valid = 4'd0;
        end

        // Timeout with busy stuck low
        dat[2]    = 8'($urandom);
        req_valid = 4'b0100;
        accept_phase(0, id);
        for (int k = 1; k < 16; k++) begin
            tick();
            check("to_no_err", 32'(err_timeout), 0);
            check("to_start", 32'(tx_start), 1);
        end
        tick();
        check("to_pulse", 32'(err_timeout), 1);
        check("to_gap_start", 32'(tx_start), 0);
        check("to_gap_active", 32'(active), 1);
        tick();
        check("to_pulse_end", 32'(err_timeout), 0);
        check("to_idle", 32'(active), 0);
        dat[3]    = 8'($urandom);
        req_valid = 4'b1000;
        accept_phase(0, id);
        busy_phase(2, 10, 4'd0);

        // Withdrawn one-cycle request during WAIT
        dat[0]    = 8'($urandom);
        req_valid = 4'b0001;
        accept_phase(0, id);
        busy_phase(3, 10, 4'b0010);
        for (int k = 0; k < 4; k++) begin
            check("wd_ready", 32'(req_ready), 0);
            check("wd_start", 32'(tx_start), 0);
            check("wd_active", 32'(active), 0);
            tick();
        end

        // Reset while in WAIT
        dat[1]    = 8'($urandom);
        req_valid = 4'b0010;
        accept_phase(0, id);
        tick();
        tx_busy = 1'b1;
        tick();
        tick();
        check("pre_rst_wait", 32'(active), 1);
        #2;
        rst_n     = 1'b0;
        req_valid = 4'd0;
        #1;
        check_reset_outputs("async_rst");
        tx_busy = 1'b0;
        tick();
        rst_n  = 1'b1;
        last_g = 3;
        tick();
        dat[2]    = 8'($urandom);
        req_valid = 4'b0100;
        accept_phase(0, id);
        busy_phase(2, 10, 4'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
